// File: rtl/inst_rom_loadable.sv
// -----------------------------------------------------------------------------
// inst_rom_loadable
//
// Run-time loadable instruction memory. An external loader streams W-bit
// instructions in CW-bit chunks into a 2**A-deep program memory. The most
// significant chunk of each word comes first. Once a load has completed, a
// registered fetch port serves the fetch stage with one cycle of latency.
//
// Parameters
//   A     address width, memory depth is 2**A words
//   W     instruction width; W must be a multiple of CW and larger than CW
//   CW    load chunk width; CPW = W/CW chunks make one word
//   FILL  value returned for fetch addresses at or beyond LoadCount
//
// Ports
//   Clk          clock, rising edge
//   Reset_n      asynchronous active-low reset
//   LoadStart    pulse, begins a new program load (ignored while loading)
//   LoadValid    LoadData is valid this cycle
//   LoadData     instruction chunk, MS chunk of each word first
//   LoadLast     marks the final chunk of the final word
//   LoadReady    block accepts a chunk this cycle (registered)
//   LoadDone     level, program loaded and fetches enabled
//   LoadErr      sticky, LoadLast arrived on a non-final chunk of a word
//   LoadCount    number of words written by the last load
//   FetchEn      fetch request this cycle
//   InstAddress  fetch address
//   InstOut      fetched instruction, registered
//   InstValid    InstOut was updated by a fetch on the previous edge
// -----------------------------------------------------------------------------
module inst_rom_loadable #(
    parameter int             A    = 8,
    parameter int             W    = 9,
    parameter int             CW   = 3,
    parameter logic [W-1:0]   FILL = '0
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            LoadStart,
    input  logic            LoadValid,
    input  logic [CW-1:0]   LoadData,
    input  logic            LoadLast,
    output logic            LoadReady,
    output logic            LoadDone,
    output logic            LoadErr,
    output logic [A:0]      LoadCount,
    input  logic            FetchEn,
    input  logic [A-1:0]    InstAddress,
    output logic [W-1:0]    InstOut,
    output logic            InstValid
);

    localparam int CPW   = W / CW;
    localparam int CCW   = (CPW > 1) ? $clog2(CPW) : 1;
    localparam int DEPTH = 2 ** A;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_READY = 2'd2
    } state_t;

    state_t              state_r;
    logic [A-1:0]        wp_r;
    logic [CCW-1:0]      chunk_r;
    // Holds the first CPW-1 chunks of the word being assembled.
    logic [W-CW-1:0]     partial_r;
    logic                load_ready_r;
    logic                load_done_r;
    logic                load_err_r;
    logic [A:0]          load_count_r;
    logic [W-1:0]        inst_out_r;
    logic                inst_valid_r;

    logic [W-1:0]        mem_r [DEPTH];

    logic                beat_s;
    logic                last_chunk_s;
    logic                wp_full_s;
    logic [W-1:0]        shifted_s;
    logic                mem_we_s;
    logic                fetch_s;
    logic                in_range_s;

    // Decode accepted beats, word completion and fetch qualification.
    always_comb begin
        beat_s       = 1'b0;
        fetch_s      = 1'b0;
        shifted_s    = {partial_r, LoadData};
        last_chunk_s = (chunk_r == CCW'(CPW - 1));
        wp_full_s    = (wp_r == {A{1'b1}});
        in_range_s   = ({1'b0, InstAddress} < load_count_r);
        if (state_r == S_LOAD) begin
            beat_s = LoadValid & load_ready_r;
        end else begin
            beat_s = 1'b0;
        end
        if (state_r == S_READY) begin
            fetch_s = FetchEn;
        end else begin
            fetch_s = 1'b0;
        end
        mem_we_s = beat_s & last_chunk_s;
    end

    // Program memory write port; contents are deliberately not reset so a
    // loaded program survives a reset of the control logic.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_r[wp_r] <= shifted_s;
        end
    end

    // Control FSM: load sequencing, status flags and the registered fetch port.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= S_IDLE;
            wp_r         <= '0;
            chunk_r      <= '0;
            partial_r    <= '0;
            load_ready_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
            load_count_r <= '0;
            inst_out_r   <= '0;
            inst_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    inst_valid_r <= 1'b0;
                    if (LoadStart) begin
                        state_r      <= S_LOAD;
                        wp_r         <= '0;
                        chunk_r      <= '0;
                        load_count_r <= '0;
                        load_done_r  <= 1'b0;
                        load_err_r   <= 1'b0;
                        load_ready_r <= 1'b1;
                    end
                end

                S_LOAD: begin
                    inst_valid_r <= 1'b0;
                    if (beat_s) begin
                        partial_r <= shifted_s[W-CW-1:0];
                        if (last_chunk_s) begin
                            // Word complete: the memory write happens on this
                            // same edge at the old write pointer.
                            chunk_r      <= '0;
                            wp_r         <= wp_r + A'(1);
                            load_count_r <= load_count_r + (A+1)'(1);
                            // Filling the top address ends the load whether or
                            // not LoadLast is present.
                            if (LoadLast || wp_full_s) begin
                                state_r      <= S_READY;
                                load_ready_r <= 1'b0;
                                load_done_r  <= 1'b1;
                            end
                        end else begin
                            chunk_r <= chunk_r + CCW'(1);
                            // Early LoadLast: the partial word is dropped and
                            // the words already written remain usable.
                            if (LoadLast) begin
                                state_r      <= S_READY;
                                load_ready_r <= 1'b0;
                                load_done_r  <= 1'b1;
                                load_err_r   <= 1'b1;
                                chunk_r      <= '0;
                            end
                        end
                    end
                end

                S_READY: begin
                    // The fetch compares against the pre-load count, so a
                    // fetch coinciding with LoadStart still completes normally.
                    if (fetch_s) begin
                        inst_out_r   <= in_range_s ? mem_r[InstAddress] : FILL;
                        inst_valid_r <= 1'b1;
                    end else begin
                        inst_valid_r <= 1'b0;
                    end
                    if (LoadStart) begin
                        state_r      <= S_LOAD;
                        wp_r         <= '0;
                        chunk_r      <= '0;
                        load_count_r <= '0;
                        load_done_r  <= 1'b0;
                        load_err_r   <= 1'b0;
                        load_ready_r <= 1'b1;
                    end
                end

                default: begin
                    state_r      <= S_IDLE;
                    load_ready_r <= 1'b0;
                    load_done_r  <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign LoadReady = load_ready_r;
    assign LoadDone  = load_done_r;
    assign LoadErr   = load_err_r;
    assign LoadCount = load_count_r;
    assign InstOut   = inst_out_r;
    assign InstValid = inst_valid_r;

endmodule

// File: tb/tb_inst_rom_loadable.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_loadable
//
// Directed self-checking bench for inst_rom_loadable, built with A=4 so the
// memory-full boundary (16 words) is reachable quickly. Inputs change 1 ns
// after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_inst_rom_loadable;

    localparam int A  = 4;
    localparam int W  = 9;
    localparam int CW = 3;

    logic            Clk;
    logic            Reset_n;
    logic            LoadStart;
    logic            LoadValid;
    logic [CW-1:0]   LoadData;
    logic            LoadLast;
    logic            LoadReady;
    logic            LoadDone;
    logic            LoadErr;
    logic [A:0]      LoadCount;
    logic            FetchEn;
    logic [A-1:0]    InstAddress;
    logic [W-1:0]    InstOut;
    logic            InstValid;

    int checks   = 0;
    int failures = 0;

    // {LoadReady, LoadDone, LoadErr, InstValid, LoadCount}
    logic [8:0] status;
    assign status = {LoadReady, LoadDone, LoadErr, InstValid, LoadCount};

    inst_rom_loadable #(
        .A    (A),
        .W    (W),
        .CW   (CW),
        .FILL (9'd0)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .LoadStart   (LoadStart),
        .LoadValid   (LoadValid),
        .LoadData    (LoadData),
        .LoadLast    (LoadLast),
        .LoadReady   (LoadReady),
        .LoadDone    (LoadDone),
        .LoadErr     (LoadErr),
        .LoadCount   (LoadCount),
        .FetchEn     (FetchEn),
        .InstAddress (InstAddress),
        .InstOut     (InstOut),
        .InstValid   (InstValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [8:0] word_val(input int i);
        int v;
        v = (i * 37 + 5) % 512;
        return v[8:0];
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_load();
        LoadStart = 1'b1;
        step();
        LoadStart = 1'b0;
    endtask

    task automatic beat(input logic [2:0] d, input logic last);
        LoadValid = 1'b1;
        LoadData  = d;
        LoadLast  = last;
        step();
        LoadValid = 1'b0;
        LoadLast  = 1'b0;
    endtask

    task automatic load_word(input logic [8:0] w, input logic last);
        beat(w[8:6], 1'b0);
        beat(w[5:3], 1'b0);
        beat(w[2:0], last);
    endtask

    task automatic fetch(input logic [3:0] a);
        FetchEn     = 1'b1;
        InstAddress = a;
        step();
        FetchEn     = 1'b0;
    endtask

    task automatic test_reset();
        #17;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (status !== 9'd0 || InstOut !== 9'd0) begin
            failures++;
            $display("FAIL reset_async status=%b inst=%h required status=0 inst=0", status, InstOut);
        end
        #12;
        @(negedge Clk);
        Reset_n = 1'b1;
        FetchEn = 1'b1;
        InstAddress = 4'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (InstValid !== 1'b0 || LoadReady !== 1'b0) begin
                failures++;
                $display("FAIL idle_fetch valid=%b ready=%b required 0 0", InstValid, LoadReady);
            end
        end
        FetchEn = 1'b0;
    endtask

    task automatic test_load_basic();
        start_load();
        checks++;
        if (status !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL load_enter status=%b required 100000000", status);
        end
        load_word(9'h171, 1'b0);
        load_word(9'h03A, 1'b0);
        load_word(9'h0DB, 1'b1);
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd3}) begin
            failures++;
            $display("FAIL load_done status=%b required 010000011", status);
        end
        fetch(4'd0);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h171) begin
            failures++;
            $display("FAIL fetch0 valid=%b inst=%h required 1 171", InstValid, InstOut);
        end
        fetch(4'd1);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h03A) begin
            failures++;
            $display("FAIL fetch1 valid=%b inst=%h required 1 03a", InstValid, InstOut);
        end
        fetch(4'd2);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h0DB) begin
            failures++;
            $display("FAIL fetch2 valid=%b inst=%h required 1 0db", InstValid, InstOut);
        end
        step();
        checks++;
        if (InstValid !== 1'b0 || InstOut !== 9'h0DB) begin
            failures++;
            $display("FAIL fetch_hold valid=%b inst=%h required 0 0db", InstValid, InstOut);
        end
    endtask

    task automatic test_fill();
        fetch(4'd5);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'd0) begin
            failures++;
            $display("FAIL fill_addr5 valid=%b inst=%h required 1 000", InstValid, InstOut);
        end
        fetch(4'd1);
        fetch(4'd3);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'd0) begin
            failures++;
            $display("FAIL fill_addr3 valid=%b inst=%h required 1 000", InstValid, InstOut);
        end
    endtask

    task automatic test_stall();
        logic [8:0] words [3];
        int         stalls [9];
        logic [8:0] w;
        words  = '{9'h171, 9'h03A, 9'h0DB};
        stalls = '{1, 0, 2, 0, 3, 1, 0, 2, 1};
        // LoadStart and a fetch in the same READY cycle.
        LoadStart   = 1'b1;
        FetchEn     = 1'b1;
        InstAddress = 4'd1;
        step();
        LoadStart = 1'b0;
        FetchEn   = 1'b0;
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h03A || LoadReady !== 1'b1 || LoadCount !== 5'd0) begin
            failures++;
            $display("FAIL start_with_fetch valid=%b inst=%h ready=%b count=%0d required 1 03a 1 0",
                     InstValid, InstOut, LoadReady, LoadCount);
        end
        for (int k = 0; k < 9; k++) begin
            w = words[k / 3];
            for (int s = 0; s < stalls[k]; s++) begin
                // Garbage on the bus without LoadValid must be ignored.
                LoadData = 3'b111;
                LoadLast = 1'b1;
                step();
                LoadLast = 1'b0;
                if (LoadReady !== 1'b1) begin
                    failures++;
                    $display("FAIL stall_ready chunk=%0d ready=%b required 1", k, LoadReady);
                end
                checks++;
            end
            case (k % 3)
                0:       beat(w[8:6], 1'b0);
                1:       beat(w[5:3], 1'b0);
                default: beat(w[2:0], k == 8);
            endcase
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd3}) begin
            failures++;
            $display("FAIL stall_done status=%b required 010000011", status);
        end
        for (int i = 0; i < 3; i++) begin
            fetch(i[3:0]);
            checks++;
            if (InstValid !== 1'b1 || InstOut !== words[i]) begin
                failures++;
                $display("FAIL stall_fetch%0d valid=%b inst=%h required 1 %h", i, InstValid, InstOut, words[i]);
            end
        end
    endtask

    task automatic test_err();
        start_load();
        load_word(9'h171, 1'b0);
        beat(3'b000, 1'b0);
        beat(3'b111, 1'b1);
        checks++;
        if (status !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL err_status status=%b required 011000001", status);
        end
        fetch(4'd1);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'd0) begin
            failures++;
            $display("FAIL err_fetch1 valid=%b inst=%h required 1 000", InstValid, InstOut);
        end
        fetch(4'd0);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h171 || LoadErr !== 1'b1) begin
            failures++;
            $display("FAIL err_fetch0 valid=%b inst=%h err=%b required 1 171 1", InstValid, InstOut, LoadErr);
        end
    endtask

    task automatic test_overflow();
        start_load();
        checks++;
        if (LoadErr !== 1'b0 || LoadDone !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b done=%b required 0 0", LoadErr, LoadDone);
        end
        for (int i = 0; i < 16; i++) begin
            load_word(word_val(i), 1'b0);
        end
        checks++;
        if (status !== {1'b0, 1'b1, 1'b0, 1'b0, 5'd16}) begin
            failures++;
            $display("FAIL full_status status=%b required 010010000", status);
        end
        // The 17th word is offered but the block is no longer accepting.
        load_word(word_val(16), 1'b1);
        checks++;
        if (LoadCount !== 5'd16 || LoadReady !== 1'b0) begin
            failures++;
            $display("FAIL full_extra count=%0d ready=%b required 16 0", LoadCount, LoadReady);
        end
        fetch(4'd15);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h030) begin
            failures++;
            $display("FAIL full_fetch15 valid=%b inst=%h required 1 030", InstValid, InstOut);
        end
        fetch(4'd0);
        checks++;
        if (InstValid !== 1'b1 || InstOut !== 9'h005) begin
            failures++;
            $display("FAIL full_fetch0 valid=%b inst=%h required 1 005", InstValid, InstOut);
        end
        // Reset in the middle of a new load.
        start_load();
        load_word(9'h1FF, 1'b0);
        beat(3'b010, 1'b0);
        #3;
        Reset_n = 1'b0;
        #1;
        checks++;
        if (status !== 9'd0 || InstOut !== 9'd0) begin
            failures++;
            $display("FAIL midload_reset status=%b inst=%h required status=0 inst=0", status, InstOut);
        end
        @(negedge Clk);
        Reset_n = 1'b1;
        FetchEn = 1'b1;
        InstAddress = 4'd0;
        step();
        step();
        FetchEn = 1'b0;
        checks++;
        if (InstValid !== 1'b0 || LoadDone !== 1'b0 || LoadCount !== 5'd0) begin
            failures++;
            $display("FAIL post_reset_fetch valid=%b done=%b count=%0d required 0 0 0",
                     InstValid, LoadDone, LoadCount);
        end
    endtask

    initial begin
        Reset_n     = 1'b1;
        LoadStart   = 1'b0;
        LoadValid   = 1'b0;
        LoadData    = 3'b000;
        LoadLast    = 1'b0;
        FetchEn     = 1'b0;
        InstAddress = 4'd0;
        test_reset();
        test_load_basic();
        test_fill();
        test_stall();
        test_err();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
